stopwatch_counter: RTL and testbench

Downstream consumer of the start/pause toggle FSM's count_en output. Divides the system clock into a 1 Hz time base that advances only while count_en is high. Keeps a 4-digit BCD MM:SS value (00:00..59:59) for the 7-segment display scanner. A synchronous clear returns the value to 00:00.

---
 rtl/stopwatch_counter_pkg.sv | 21 ++
 rtl/stopwatch_counter_bcd_digit.sv | 32 +++
 rtl/stopwatch_counter.sv | 103 ++++++++++
 tb/tb_stopwatch_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_counter_pkg.sv
// Shared stopwatch constants: BCD digit width and per-digit limits for MM:SS.
// The display scanner imports the same limits, so they live here.
// No logic; types and constants only.
package stopwatch_counter_pkg;

  localparam int BCD_W = 4;

  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_ONES_MAX = 9;
  localparam int MIN_TENS_MAX = 5;

  // Display value, most significant digit first.
  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } mmss_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit counting 0..MAX, with clear and increment-enable.
// q updates on the edge after inc; carry is combinational (inc && q==MAX).
// No backpressure: inc is honoured every cycle it is high.
module bcd_digit
  import stopwatch_counter_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] MAX_Q = BCD_W'(MAX);

  assign carry = inc && (q == MAX_Q);

  // Digit register: clear wins over increment; wrap to 0 past MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == MAX_Q) ? '0 : q + BCD_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch: prescaler divides clk down to 1 Hz ticks gated by count_en.
// Digits, sec_pulse and rollover update on the edge the tick fires (all registered).
// No backpressure; pausing (count_en=0) freezes the prescaler mid-second.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             clr,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             sec_pulse,
  output logic             rollover
);

  // Derived width; guarded so a degenerate TICK_DIV still yields one bit.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic             tick;
  logic             so_carry;
  logic             st_carry;
  logic             mo_carry;
  logic             mt_carry;
  mmss_t            disp;

  // Tick uses count_en sampled on this edge, so a pause landing on the last
  // prescaler count holds at PRESC_LAST and fires on the first resumed edge.
  assign tick = count_en && (presc == PRESC_LAST);

  // Prescaler: advances only while enabled, holding any fractional second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (count_en) begin
      presc <= tick ? '0 : presc + CNT_W'(1);
    end
  end

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (tick),
    .q     (disp.sec_ones),
    .carry (so_carry)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (so_carry),
    .q     (disp.sec_tens),
    .carry (st_carry)
  );

  bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (st_carry),
    .q     (disp.min_ones),
    .carry (mo_carry)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (mo_carry),
    .q     (disp.min_tens),
    .carry (mt_carry)
  );

  // Status strobes, aligned with the digit values they describe; clr suppresses both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_pulse <= 1'b0;
      rollover  <= 1'b0;
    end else if (clr) begin
      sec_pulse <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      sec_pulse <= tick;
      rollover  <= mt_carry;
    end
  end

  assign sec_ones = disp.sec_ones;
  assign sec_tens = disp.sec_tens;
  assign min_ones = disp.min_ones;
  assign min_tens = disp.min_tens;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with TICK_DIV=4.
// Reference model counts elapsed seconds and prescaler phase as plain integers.
// Monitor compares every edge's outputs on the following falling edge.
module tb_stopwatch_counter;

  localparam int TICK = 4;

  logic       clk;
  logic       rst;
  logic       count_en;
  logic       clr;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       sec_pulse;
  logic       rollover;

  stopwatch_counter #(.TICK_DIV(TICK)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_en  (count_en),
    .clr       (clr),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .sec_pulse (sec_pulse),
    .rollover  (rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector: {mt, mo, st, so, sec_pulse, rollover}.
  typedef struct {
    int unsigned tag;
    logic [17:0] exp;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int unsigned edge_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference state.
  int m_secs;   // elapsed seconds modulo one hour
  int m_frac;   // enabled edges since the last counted second
  bit m_pulse;
  bit m_roll;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [17:0] model_vec();
    int mm;
    int ss;
    mm = m_secs / 60;
    ss = m_secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m_pulse, m_roll};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {min_tens, min_ones, sec_tens, sec_ones, sec_pulse, rollover};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_frac = 0; m_pulse = 0; m_roll = 0;
  endtask

  task automatic model_edge(input bit en, input bit c);
    m_pulse = 0;
    m_roll  = 0;
    if (c) begin
      m_secs = 0;
      m_frac = 0;
    end else if (en) begin
      m_frac = m_frac + 1;
      if (m_frac == TICK) begin
        m_frac  = 0;
        m_secs  = (m_secs + 1) % 3600;
        m_pulse = 1;
        m_roll  = (m_secs == 0);
      end
    end
  endtask

  task automatic compare(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h%0h:%0h%0h p=%b r=%b, want %0h%0h:%0h%0h p=%b r=%b",
               name, $time, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: after each rising edge, check the entry that edge was meant to produce.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
      sb_entry_t e;
      e = sb.pop_front();
      if (e.tag == edge_cnt) compare("edge", dut_vec(), e.exp);
      else compare("stale_entry", 18'h3ffff, e.exp);
    end
  end

  // One clock edge of stimulus; expected result queued for the monitor.
  task automatic step(input bit en, input bit c);
    sb_entry_t e;
    count_en = en;
    clr      = c;
    model_edge(en, c);
    e.tag = edge_cnt + 1;
    e.exp = model_vec();
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 1'b0);
  endtask

  // Assert rst between edges, check it acts without a clock, then release.
  task automatic async_reset(input bit en_during);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    compare("rst_async", dut_vec(), model_vec());
    count_en = en_during;
    clr      = 1'b0;
    @(posedge clk);
    #1;
    compare("rst_held", dut_vec(), model_vec());
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    count_en = 1'b0;
    clr      = 1'b0;
    model_reset();

    // 1: reset asserted before any clock edge, then idle while paused.
    #3;
    rst = 1'b1;
    #1;
    compare("rst_noclk", dut_vec(), 18'h0);
    @(posedge clk);
    #1;
    compare("rst_hold", dut_vec(), 18'h0);
    rst = 1'b0;
    run(5, 1'b0);

    // 2: plain counting to 00:01, 00:10, 01:00.
    run(4, 1'b1);
    run(36, 1'b1);
    run(200, 1'b1);

    // 3: pause mid-second preserves the fraction.
    step(1'b0, 1'b1);
    run(2, 1'b1);
    run(10, 1'b0);
    run(2, 1'b1);

    // Pause landing on the would-be tick edge; tick fires on resume.
    run(3, 1'b1);
    step(1'b0, 1'b0);
    run(3, 1'b0);
    step(1'b1, 1'b0);

    // 4: wrap 59:59 -> 00:00 with rollover.
    step(1'b0, 1'b1);
    run(14396, 1'b1);
    run(4, 1'b1);
    run(8, 1'b1);

    // 5: clear coinciding with the 00:06 -> 00:07 tick.
    step(1'b0, 1'b1);
    run(27, 1'b1);
    step(1'b1, 1'b1);
    run(4, 1'b1);

    // 6: asynchronous reset while running at 12:34.
    step(1'b0, 1'b1);
    run(754 * TICK + 2, 1'b1);
    async_reset(1'b1);
    run(4, 1'b1);

    // Randomized enable/clear traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
    end
    for (int k = 0; k < 3; k++) begin
      run($urandom_range(1, 40), 1'b1);
      async_reset($urandom_range(0, 1) == 1);
    end
    run(20, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
